// File: rtl/seq_det_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seq_det_pkg
// Description : Shared constants and helpers for the programmable serial
//               sequence detector: legal MAX_LEN range, length-port width,
//               pattern-length clamp and the reset-time pattern defaults.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package seq_det_pkg;

    // Legal range for the maximum pattern length.
    localparam int MAX_LEN_MIN = 2;
    localparam int MAX_LEN_MAX = 16;

    // Default parameter values for the detector.
    localparam int DEF_MAX_LEN = 8;
    localparam int DEF_CNT_W   = 8;
    localparam int DEF_PAT_RST = 0;
    localparam int DEF_LEN_RST = 3;

    // True when a MAX_LEN value lies inside the supported range.
    function automatic bit max_len_ok(input int max_len);
        return (max_len >= MAX_LEN_MIN) && (max_len <= MAX_LEN_MAX);
    endfunction

    // Width of a field that must hold every value 0..max_len.
    function automatic int calc_lw(input int max_len);
        return $clog2(max_len + 1);
    endfunction

    // Requested lengths of 0 and 1 both mean a one-bit pattern; anything
    // longer than the hardware supports is trimmed to the maximum.
    function automatic int clamp_len(input int req_len, input int max_len);
        if (req_len < 1) begin
            return 1;
        end
        if (req_len > max_len) begin
            return max_len;
        end
        return req_len;
    endfunction

endpackage : seq_det_pkg
`default_nettype wire

// File: rtl/seq_hist_shreg.sv
`default_nettype none
// ============================================================================
// Module      : seq_hist_shreg
// Description : Shift history of previously accepted serial bits plus a
//               saturating count of how many of them are meaningful.
//               A load clears everything; a non-overlapping match clears the
//               count only, which makes the stale history bits irrelevant.
// Ports       : clk        - rising-edge clock
//               rst        - asynchronous active-low reset
//               load_clr   - pattern load this cycle (clears hist and fill)
//               shift_en   - accepted sample this cycle (valid, no load)
//               match_clr  - non-overlapping match on the accepted sample
//               inp        - serial data bit
//               hist       - history, bit 0 = newest accepted bit
//               fill       - number of valid history bits
// Revision    : 1.0 - initial release
// ============================================================================
module seq_hist_shreg
    import seq_det_pkg::*;
#(
    parameter  int MAX_LEN = DEF_MAX_LEN,
    localparam int LW      = calc_lw(MAX_LEN),
    localparam int HIST_W  = MAX_LEN - 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_clr,
    input  logic              shift_en,
    input  logic              match_clr,
    input  logic              inp,
    output logic [HIST_W-1:0] hist,
    output logic [LW-1:0]     fill
);

    // fill never needs to exceed the history depth: the longest pattern
    // consumes HIST_W stored bits plus the live input bit.
    localparam logic [LW-1:0] FILL_MAX = LW'(HIST_W);

    logic [HIST_W-1:0] hist_q;
    logic [HIST_W-1:0] hist_d;
    logic [HIST_W-1:0] w_hist_shifted;
    logic [LW-1:0]     fill_q;
    logic [LW-1:0]     fill_d;

    // A one-bit history has nothing to shift up, so it simply takes inp.
    if (HIST_W > 1) begin : g_hist_multi
        assign w_hist_shifted = {hist_q[HIST_W-2:0], inp};
    end else begin : g_hist_single
        assign w_hist_shifted = inp;
    end

    always_comb begin
        hist_d = hist_q;
        fill_d = fill_q;
        if (load_clr) begin
            hist_d = '0;
            fill_d = '0;
        end else if (shift_en) begin
            hist_d = w_hist_shifted;
            if (match_clr) begin
                fill_d = '0;
            end else if (fill_q != FILL_MAX) begin
                fill_d = fill_q + LW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hist_q <= '0;
            fill_q <= '0;
        end else begin
            hist_q <= hist_d;
            fill_q <= fill_d;
        end
    end

    assign hist = hist_q;
    assign fill = fill_q;

endmodule : seq_hist_shreg
`default_nettype wire

// File: rtl/seq_det_prog.sv
`default_nettype none
// ============================================================================
// Module      : seq_det_prog
// Description : Programmable-pattern serial bit-sequence detector. Compares
//               the serial stream against a runtime-loadable pattern of
//               1..MAX_LEN bits, with overlapping or non-overlapping
//               detection and a saturating match counter.
// Ports       : clk       - rising-edge clock
//               rst       - asynchronous active-low reset
//               inp       - serial data bit
//               in_vld    - inp is sampled only when high
//               ovl_en    - 1 = overlapping, 0 = non-overlapping detection
//               pat_load  - load pat_val / pat_len this cycle
//               pat_val   - new pattern, bit 0 = last bit of the sequence
//               pat_len   - new length (0/1 -> 1, >MAX_LEN -> MAX_LEN)
//               det       - Mealy match flag (same cycle as final bit)
//               det_cnt   - saturating number of matches since reset/load
// Revision    : 1.0 - initial release
// ============================================================================
module seq_det_prog
    import seq_det_pkg::*;
#(
    parameter  int                 MAX_LEN = DEF_MAX_LEN,
    parameter  int                 CNT_W   = DEF_CNT_W,
    parameter  logic [MAX_LEN-1:0] PAT_RST = MAX_LEN'(DEF_PAT_RST),
    parameter  int                 LEN_RST = DEF_LEN_RST,
    localparam int                 LW      = calc_lw(MAX_LEN)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               inp,
    input  logic               in_vld,
    input  logic               ovl_en,
    input  logic               pat_load,
    input  logic [MAX_LEN-1:0] pat_val,
    input  logic [LW-1:0]      pat_len,
    output logic               det,
    output logic [CNT_W-1:0]   det_cnt
);

    localparam int HIST_W = MAX_LEN - 1;

    // Reset length goes through the same clamp as a runtime load so an
    // out-of-range LEN_RST can never leave the comparator with len = 0.
    localparam logic [LW-1:0] LEN_RST_C = LW'(clamp_len(LEN_RST, MAX_LEN));

    if (!max_len_ok(MAX_LEN)) begin : g_bad_max_len
        $error("seq_det_prog: MAX_LEN must be within 2..16");
    end

    logic [MAX_LEN-1:0] pat_q;
    logic [MAX_LEN-1:0] pat_d;
    logic [LW-1:0]      len_q;
    logic [LW-1:0]      len_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   cnt_d;

    logic [HIST_W-1:0]  w_hist;
    logic [LW-1:0]      w_fill;
    logic [MAX_LEN-1:0] w_window;
    logic [MAX_LEN-1:0] w_mask;
    logic               w_sample;
    logic               w_fill_ok;
    logic               w_pat_eq;
    logic               w_match;

    // A sample is only consumed when valid and not overridden by a load.
    assign w_sample = in_vld & ~pat_load;

    seq_hist_shreg #(
        .MAX_LEN (MAX_LEN)
    ) u_hist (
        .clk       (clk),
        .rst       (rst),
        .load_clr  (pat_load),
        .shift_en  (w_sample),
        .match_clr (w_match & ~ovl_en),
        .inp       (inp),
        .hist      (w_hist),
        .fill      (w_fill)
    );

    // The live bit completes the window, so only len-1 stored bits are
    // required: fill >= len-1 is evaluated as fill+1 >= len to avoid
    // any underflow on the subtraction.
    assign w_window  = {w_hist, inp};
    assign w_fill_ok = ({1'b0, w_fill} + (LW+1)'(1)) >= {1'b0, len_q};

    // Only the low len bits of the window take part in the compare.
    always_comb begin
        w_mask = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            w_mask[i] = (i < int'(len_q));
        end
    end

    assign w_pat_eq = (((w_window ^ pat_q) & w_mask) == '0);
    assign w_match  = w_sample & w_fill_ok & w_pat_eq;
    assign det      = w_match;

    // Pattern / length registers.
    always_comb begin
        pat_d = pat_q;
        len_d = len_q;
        if (pat_load) begin
            pat_d = pat_val;
            len_d = LW'(clamp_len(int'(pat_len), MAX_LEN));
        end
    end

    // Saturating match counter; a load restarts the count.
    always_comb begin
        cnt_d = cnt_q;
        if (pat_load) begin
            cnt_d = '0;
        end else if (w_match && !(&cnt_q)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pat_q <= PAT_RST;
            len_q <= LEN_RST_C;
            cnt_q <= '0;
        end else begin
            pat_q <= pat_d;
            len_q <= len_d;
            cnt_q <= cnt_d;
        end
    end

    assign det_cnt = cnt_q;

endmodule : seq_det_prog
`default_nettype wire

// File: tb/tb_seq_det_prog.sv
`default_nettype none
// ============================================================================
// Module      : tb_seq_det_prog
// Description : Self-checking bench for seq_det_prog. Two instances share
//               all inputs: one with an 8-bit counter, one with a 2-bit
//               counter to exercise saturation. A queue-based reference
//               model predicts det and both counters every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_det_prog;

    localparam int MAX_LEN = 8;
    localparam int LW      = 4;

    logic               clk = 1'b0;
    logic               rst;
    logic               inp;
    logic               in_vld;
    logic               ovl_en;
    logic               pat_load;
    logic [MAX_LEN-1:0] pat_val;
    logic [LW-1:0]      pat_len;
    logic               det_a;
    logic               det_b;
    logic [7:0]         cnt_a;
    logic [1:0]         cnt_b;

    always #5 clk = ~clk;

    seq_det_prog #(
        .MAX_LEN (MAX_LEN),
        .CNT_W   (8),
        .PAT_RST (8'h00),
        .LEN_RST (3)
    ) u_dut_a (
        .clk      (clk),
        .rst      (rst),
        .inp      (inp),
        .in_vld   (in_vld),
        .ovl_en   (ovl_en),
        .pat_load (pat_load),
        .pat_val  (pat_val),
        .pat_len  (pat_len),
        .det      (det_a),
        .det_cnt  (cnt_a)
    );

    seq_det_prog #(
        .MAX_LEN (MAX_LEN),
        .CNT_W   (2),
        .PAT_RST (8'h00),
        .LEN_RST (3)
    ) u_dut_b (
        .clk      (clk),
        .rst      (rst),
        .inp      (inp),
        .in_vld   (in_vld),
        .ovl_en   (ovl_en),
        .pat_load (pat_load),
        .pat_val  (pat_val),
        .pat_len  (pat_len),
        .det      (det_b),
        .det_cnt  (cnt_b)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // hq holds the accepted bits that may still count towards a match,
    // oldest first; a non-overlapping match or a load empties it.
    logic [7:0] m_pat;
    int         m_len;
    bit         hq[$];
    int         m_cnt_a;
    int         m_cnt_b;
    logic       last_det;

    task automatic model_reset();
        m_pat   = 8'h00;
        m_len   = 3;
        hq.delete();
        m_cnt_a = 0;
        m_cnt_b = 0;
    endtask

    function automatic bit model_match(input bit b, input bit v, input bit ld);
        bit w;
        if (!v || ld) return 1'b0;
        if (hq.size() < m_len - 1) return 1'b0;
        // Sequence position k counts back from the newest bit (k = 0).
        for (int k = 0; k < m_len; k++) begin
            w = (k == 0) ? b : hq[hq.size() - k];
            if (w != m_pat[k]) return 1'b0;
        end
        return 1'b1;
    endfunction

    // One clock cycle: drive at negedge, check the combinational det and
    // the registered counters, then advance the model at the posedge.
    task automatic step(input bit b, input bit v, input bit ld,
                        input logic [7:0] pv, input logic [3:0] pl);
        bit m;
        int pli;
        @(negedge clk);
        inp      = b;
        in_vld   = v;
        pat_load = ld;
        pat_val  = pv;
        pat_len  = pl;
        #1;
        m = model_match(b, v, ld);
        chk("det_a", det_a, m);
        chk("det_b", det_b, m);
        chk("cnt_a", cnt_a, m_cnt_a);
        chk("cnt_b", cnt_b, m_cnt_b);
        last_det = det_a;
        @(posedge clk);
        if (ld) begin
            pli     = int'(pl);
            m_pat   = pv;
            m_len   = (pli < 1) ? 1 : ((pli > MAX_LEN) ? MAX_LEN : pli);
            hq.delete();
            m_cnt_a = 0;
            m_cnt_b = 0;
        end else if (v) begin
            hq.push_back(b);
            if (hq.size() > MAX_LEN - 1) void'(hq.pop_front());
            if (m) begin
                m_cnt_a = (m_cnt_a < 255) ? m_cnt_a + 1 : 255;
                m_cnt_b = (m_cnt_b < 3) ? m_cnt_b + 1 : 3;
                if (!ovl_en) hq.delete();
            end
        end
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, 8'h00, 4'd0);
    endtask

    task automatic load(input logic [7:0] pv, input logic [3:0] pl);
        step(1'b1, 1'b1, 1'b1, pv, pl);
    endtask

    // Feed n valid bits, bits[n-1] first.
    task automatic feed(input logic [15:0] bits, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            step(bits[i], 1'b1, 1'b0, 8'h00, 4'd0);
        end
    endtask

    initial begin
        rst      = 1'b0;
        inp      = 1'b0;
        in_vld   = 1'b0;
        ovl_en   = 1'b0;
        pat_load = 1'b0;
        pat_val  = '0;
        pat_len  = '0;
        last_det = 1'b0;
        model_reset();

        repeat (2) @(negedge clk);
        #1;
        chk("rst_det", det_a, 0);
        chk("rst_cnt", cnt_a, 0);
        @(negedge clk);
        rst = 1'b1;

        // Default pattern 000, len 3, non-overlapping.
        ovl_en = 1'b0;
        feed(16'b000000, 6);
        idle();
        chk("t1_cnt", cnt_a, 2);

        // Same stream, overlapping.
        ovl_en = 1'b1;
        load(8'h00, 4'd3);
        feed(16'b000000, 6);
        idle();
        chk("t2_cnt", cnt_a, 4);

        // Pattern 1011, overlapping then non-overlapping.
        load(8'h0B, 4'd4);
        feed(16'b1011011, 7);
        idle();
        chk("t3_ovl_cnt", cnt_a, 2);
        ovl_en = 1'b0;
        load(8'h0B, 4'd4);
        feed(16'b1011011, 7);
        idle();
        chk("t3_novl_cnt", cnt_a, 1);

        // Gap in the valid stream.
        load(8'h0B, 4'd4);
        feed(16'b10, 2);
        repeat (5) idle();
        feed(16'b11, 2);
        chk("gap_det", last_det, 1);
        idle();
        chk("gap_cnt", cnt_a, 1);

        // Load coinciding with a would-be matching bit.
        load(8'h0B, 4'd4);
        feed(16'b101, 3);
        step(1'b1, 1'b1, 1'b1, 8'h0B, 4'd4);
        chk("ld_det", last_det, 0);
        idle();
        chk("ld_cnt", cnt_a, 0);

        // Length clamps: 0 -> 1, 12 -> 8.
        load(8'h01, 4'd0);
        feed(16'b101, 3);
        idle();
        chk("clamp0_cnt", cnt_a, 2);
        ovl_en = 1'b1;
        load(8'h11, 4'd12);
        feed(16'b00010001, 8);
        idle();
        chk("clamp12_cnt", cnt_a, 1);

        // Saturation of the narrow counter.
        load(8'hFF, 4'd1);
        feed(16'b111111, 6);
        idle();
        chk("sat_cnt_b", cnt_b, 3);
        chk("sat_cnt_a", cnt_a, 6);

        // Asynchronous reset in the middle of a cycle.
        @(negedge clk);
        inp    = 1'b1;
        in_vld = 1'b1;
        #1;
        chk("pre_rst_det_b", det_b, 1);
        #1;
        rst = 1'b0;
        #1;
        chk("arst_det_a", det_a, 0);
        chk("arst_det_b", det_b, 0);
        chk("arst_cnt_a", cnt_a, 0);
        chk("arst_cnt_b", cnt_b, 0);
        model_reset();
        @(negedge clk);
        in_vld = 1'b0;
        rst    = 1'b1;

        // Randomised traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            logic [3:0] pl;
            if ($urandom_range(0, 63) == 0) ovl_en = $urandom_range(0, 1);
            if ($urandom_range(0, 39) == 0) begin
                if ($urandom_range(0, 9) < 7) pl = 4'($urandom_range(1, 4));
                else                          pl = 4'($urandom_range(0, 15));
                step($urandom_range(0, 1), $urandom_range(0, 1), 1'b1,
                     8'($urandom), pl);
            end else begin
                step($urandom_range(0, 1), ($urandom_range(0, 3) != 0), 1'b0,
                     8'($urandom), 4'($urandom));
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule : tb_seq_det_prog
`default_nettype wire
